seq_signed_mult_core: RTL and testbench

//  Parametrised sequential signed shift-add multiplier with a start / valid-ready handshake.

---
 rtl/seq_signed_mult_core_if.sv | 31 +++
 rtl/seq_signed_mult_core.sv | 146 ++++++++++++++
 tb/tb_seq_signed_mult_core.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seq_signed_mult_core_if.sv
// -----------------------------------------------------------------------------
// seq_signed_mult_core_if
// Handshake and data bundle for the sequential signed multiplier.
//   master : operand/request side (capture logic, testbench)
//   slave  : the multiplier core
// -----------------------------------------------------------------------------
interface seq_signed_mult_core_if #(
  parameter int WIDTH = 8
) ();

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic [2*WIDTH-1:0]   product_mag;
  logic                 product_neg;

  modport master (
    output start, a, b, out_ready,
    input  busy, out_valid, product, product_mag, product_neg
  );

  modport slave (
    input  start, a, b, out_ready,
    output busy, out_valid, product, product_mag, product_neg
  );

endinterface

// File: rtl/seq_signed_mult_core.sv
// -----------------------------------------------------------------------------
// seq_signed_mult_core
// Sequential signed shift-add multiplier, one multiplier bit per clock.
// Operands are converted to magnitudes on capture, multiplied unsigned, and
// the sign is re-applied when the result is registered on entry to DONE.
// The result is offered both as two's complement and as sign + magnitude.
//
// Build option:
//   SSM_EARLY_TERM_EN  when defined, CALC stops as soon as the remaining
//                      multiplier bits are all zero (data-dependent latency).
//                      Undefined: always WIDTH CALC cycles.
// -----------------------------------------------------------------------------
module seq_signed_mult_core #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_signed_mult_core_if.slave   bus
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      mc_q, mc_d;        // shifted multiplicand magnitude
  logic [WIDTH-1:0]   mp_q, mp_d;        // remaining multiplier magnitude bits
  logic [PW-1:0]      acc_q, acc_d;      // partial-product accumulator
  logic [CNT_W-1:0]   cnt_q, cnt_d;      // CALC iteration index
  logic               neg_q, neg_d;      // operand signs differ
  logic [PW-1:0]      product_q, product_d;
  logic [PW-1:0]      mag_q, mag_d;
  logic               pneg_q, pneg_d;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which
  // still fits WIDTH bits when read as unsigned.
  logic [WIDTH-1:0]   abs_a, abs_b;
  assign abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

  // CALC-step datapath terms
  logic [PW-1:0]      acc_sum;
  logic [WIDTH-1:0]   mp_shift;
  logic               last_iter;
  logic               res_neg;

  // State and datapath register update
  // NOTE: every register here uses <= so all of them sample the same pre-edge
  // values; blocking assignments would let later lines see already-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mc_q      <= '0;
      mp_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      mag_q     <= '0;
      pneg_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mc_q      <= mc_d;
      mp_q      <= mp_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      mag_q     <= mag_d;
      pneg_q    <= pneg_d;
    end
  end

  // Next-state and datapath logic for IDLE -> CALC -> DONE -> IDLE
  // NOTE: every variable gets a hold/default value first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mc_d      = mc_q;
    mp_d      = mp_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    mag_d     = mag_q;
    pneg_d    = pneg_q;

    acc_sum   = mp_q[0] ? (acc_q + mc_q) : acc_q;
    mp_shift  = mp_q >> 1;
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef SSM_EARLY_TERM_EN
    // Nothing left to add once the remaining multiplier bits are zero.
    last_iter = last_iter || (mp_shift == '0);
`endif
    res_neg   = neg_q && (acc_sum != '0);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mc_d    = {{WIDTH{1'b0}}, abs_a};
          mp_d    = abs_b;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        acc_d = acc_sum;
        mc_d  = mc_q << 1;
        mp_d  = mp_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          // Register the result on the way into DONE; a zero product is
          // never reported as negative.
          mag_d     = acc_sum;
          pneg_d    = res_neg;
          product_d = res_neg ? -acc_sum : acc_sum;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        // Result held until the consumer accepts; start is ignored here.
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.product     = product_q;
  assign bus.product_mag = mag_q;
  assign bus.product_neg = pneg_q;

endmodule

// File: tb/tb_seq_signed_mult_core.sv
// -----------------------------------------------------------------------------
// tb_seq_signed_mult_core
// Directed self-checking bench for seq_signed_mult_core at WIDTH=8.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Expected latencies follow the SSM_EARLY_TERM_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_seq_signed_mult_core;

  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  seq_signed_mult_core_if #(.WIDTH(WIDTH)) bus ();

  seq_signed_mult_core #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One comparison: counted, and reported on mismatch.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Edges from the start edge to out_valid high, for multiplier b.
  function automatic int exp_latency(input logic [7:0] b);
`ifdef SSM_EARLY_TERM_EN
    logic [7:0] m;
    int         hi;
    m  = b[7] ? -b : b;
    hi = 0;
    for (int i = 0; i < 8; i++) if (m[i]) hi = i + 1;
    return 1 + ((hi == 0) ? 1 : hi);
`else
    return 1 + WIDTH;
`endif
  endfunction

  // Present operands with a one-cycle start pulse; returns after the start edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for out_valid and check the edge count since start.
  task automatic wait_valid(input string tag, input int exp_lat);
    int edges;
    edges = 1;
    while (!bus.out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, edges, exp_lat);
  endtask

  task automatic check_result(input string tag, input logic [15:0] prod,
                              input logic [15:0] mag, input logic neg);
    check({tag, " product"},     bus.product,     prod);
    check({tag, " product_mag"}, bus.product_mag, mag);
    check({tag, " product_neg"}, bus.product_neg, neg);
  endtask

  // One-edge acceptance pulse; core must be back in IDLE afterwards.
  task automatic accept(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " out_valid after accept"}, bus.out_valid, 1'b0);
    check({tag, " busy after accept"},      bus.busy,      1'b0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #3;
    check("reset busy",        bus.busy,        1'b0);
    check("reset out_valid",   bus.out_valid,   1'b0);
    check("reset product",     bus.product,     16'h0000);
    check("reset product_mag", bus.product_mag, 16'h0000);
    check("reset product_neg", bus.product_neg, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 5 * -3 = -15
    start_op(8'd5, 8'hFD);
    check("5*-3 busy in CALC", bus.busy, 1'b1);
    wait_valid("5*-3", exp_latency(8'hFD));
    check_result("5*-3", 16'hFFF1, 16'd15, 1'b1);
    check("5*-3 busy in DONE", bus.busy, 1'b1);
    accept("5*-3");

    // -128 * -128 = 16384
    start_op(8'h80, 8'h80);
    wait_valid("-128*-128", exp_latency(8'h80));
    check_result("-128*-128", 16'h4000, 16'h4000, 1'b0);
    accept("-128*-128");

    // -128 * 127 = -16256
    start_op(8'h80, 8'h7F);
    wait_valid("-128*127", exp_latency(8'h7F));
    check_result("-128*127", 16'hC080, 16'h3F80, 1'b0 ^ 1'b1);
    accept("-128*127");

    // -77 * 0 = 0, zero product never negative
    start_op(8'hB3, 8'h00);
    wait_valid("-77*0", exp_latency(8'h00));
    check_result("-77*0", 16'h0000, 16'h0000, 1'b0);
    accept("-77*0");

    // 127 * 127 = 16129 and 1 * -1 = -1
    start_op(8'h7F, 8'h7F);
    wait_valid("127*127", exp_latency(8'h7F));
    check_result("127*127", 16'h3F01, 16'h3F01, 1'b0);
    accept("127*127");

    start_op(8'h01, 8'hFF);
    wait_valid("1*-1", exp_latency(8'hFF));
    check_result("1*-1", 16'hFFFF, 16'h0001, 1'b1);
    accept("1*-1");

    // Stall in DONE for 20 cycles: 7 * 6 = 42 held; start in DONE ignored
    start_op(8'd7, 8'd6);
    wait_valid("stall 7*6", exp_latency(8'd6));
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        bus.a     = 8'd100;
        bus.b     = 8'd100;
        bus.start = 1'b1;
      end
      @(posedge clk); #1;
      check("stall out_valid", bus.out_valid, 1'b1);
      check("stall product",   bus.product,   16'd42);
    end
    // start still high on the accepting edge: must not launch a new operation
    accept("stall 7*6");
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("no queued op busy", bus.busy, 1'b0);

    // start pulsed mid-CALC with new operands: 12 * -11 = -132
    start_op(8'd12, 8'hF5);
    @(posedge clk); #1;
    bus.a     = 8'd100;
    bus.b     = 8'd100;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_valid("midcalc 12*-11", exp_latency(8'hF5) - 2);
    check_result("midcalc 12*-11", 16'hFF7C, 16'd132, 1'b1);
    accept("midcalc 12*-11");
    @(posedge clk); #1;
    check("midcalc no queued op", bus.busy, 1'b0);

    // Asynchronous reset mid-CALC, then -9 * 9 = -81 after release
    start_op(8'hF7, 8'd9);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midreset busy",        bus.busy,        1'b0);
    check("midreset out_valid",   bus.out_valid,   1'b0);
    check("midreset product",     bus.product,     16'h0000);
    check("midreset product_mag", bus.product_mag, 16'h0000);
    check("midreset product_neg", bus.product_neg, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(8'hF7, 8'd9);
    wait_valid("-9*9", exp_latency(8'd9));
    check_result("-9*9", 16'hFFAF, 16'd81, 1'b1);
    accept("-9*9");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
